rx_frame_assembler: RTL and testbench
=====================================

Name: rx_frame_assembler

Overview:
Parametrised UART receive-frame assembler. Takes the byte stream from the RS-232 receiver (RS_DATAOUT qualified by RS_DONE) and builds frames of the form: 1 command byte, ADDR_BYTES address bytes, DATA_BYTES data bytes. Each complete frame is presented atomically to the scoreboard manager with a one-cycle strobe. An inter-byte timeout discards a stalled partial frame and resynchronises the parser.

Parameters:
ADDR_BYTES, 1, number of address bytes per frame (1..4)
DATA_BYTES, 1, number of data bytes per frame (1..4)
TIMEOUT_CYCLES, 500000, max clock cycles between bytes inside a frame (10 ms at 50 MHz); minimum 2

Ports:
CLK_50MHZ  input  1  system clock, 50 MHz
RST  input  1  synchronous reset, active-high
RS_DATAOUT  input  8  received byte; valid only in a cycle with RS_DONE=1
RS_DONE  input  1  one-cycle pulse, byte available
frame_valid  output  1  one-cycle pulse, new frame on cmd_rx/addr_rx/data_rx
cmd_rx  output  8  command byte of the last good frame
addr_rx  output  8*ADDR_BYTES  address of the last good frame, first received byte = MSB
data_rx  output  8*DATA_BYTES  data of the last good frame, first received byte = MSB
frame_err  output  1  one-cycle pulse, partial frame discarded
busy  output  1  high while a frame is partially received

Behaviour:
- Reset and clock: synchronous, active-high RST; clock CLK_50MHZ. RST has priority over all other activity.
- Reset values: frame_valid=0, frame_err=0, busy=0, cmd_rx=0, addr_rx=0, data_rx=0, all shadow registers=0, state=S_CMD, timeout counter=0.
- States:
  - S_CMD: on RS_DONE, capture byte into shadow cmd. Go to S_ADDR.
  - S_ADDR: on RS_DONE, shift byte into shadow addr (shift left 8, new byte in LSBs) and increment the byte counter. After ADDR_BYTES bytes, clear the counter and go to S_DATA.
  - S_DATA: shift into shadow data the same way. After DATA_BYTES bytes, go to S_DONE (or S_CHK when the optional feature is enabled).
  - S_DONE: copy all shadow registers to the outputs and pulse frame_valid for exactly 1 cycle. Go to S_CMD.
    - If RS_DONE=1 in this cycle, the byte is taken as the next command byte and the next state is S_ADDR. No byte is ever dropped.
- Latency: frame_valid is high the cycle after the RS_DONE of the final frame byte. Outputs change only in that cycle and hold until the next good frame.
- busy: 1 in S_ADDR, S_DATA and S_CHK; 0 in S_CMD and S_DONE.
- Timeout counter (width $clog2(TIMEOUT_CYCLES)):
  - Cleared on every RS_DONE and while in S_CMD or S_DONE; otherwise increments while busy.
  - When the counter reaches TIMEOUT_CYCLES-1 and RS_DONE=0: pulse frame_err for 1 cycle, discard the shadow registers (outputs untouched), clear counter and byte counter, go to S_CMD.
  - RS_DONE in the same cycle as expiry: the byte wins. It is accepted normally, no error, and the counter restarts.
- Byte counter width: $clog2(max(ADDR_BYTES,DATA_BYTES))+1. No wrap within a frame.
- frame_valid and frame_err are never high in the same cycle.
- Reset mid-frame: partial frame lost silently; no frame_err.

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined: one checksum byte follows the data bytes (state S_CHK).
  - Checksum = 8-bit sum modulo 256 of the cmd, addr and data bytes, accumulated on each RS_DONE and cleared at frame start.
  - Match: S_DONE behaviour as above.
  - Mismatch: frame_err pulses the cycle after the checksum RS_DONE; no frame_valid; outputs unchanged; go to S_CMD.
  - Timeout rules also apply in S_CHK.
- Not defined: no S_CHK state, no accumulator logic; the frame ends after the last data byte.

Test Plan:
- Frame timing: ADDR_BYTES=1, DATA_BYTES=2, bytes 0x01,0x10,0xAB,0xCD with 20-cycle gaps -> frame_valid 1 cycle after the 4th RS_DONE; cmd_rx=0x01, addr_rx=0x10, data_rx=0xABCD; busy high from after byte 1 until frame_valid.
- Timeout: TIMEOUT_CYCLES=100, send 0x02,0x20 then stop -> frame_err pulses once ~99 cycles after the 2nd RS_DONE; outputs keep the previous frame; the next bytes 0x03,0x30,0x11,0x22 yield cmd=0x03, addr=0x30, data=0x1122.
- Back-to-back frames: two frames where the first byte of frame 2 arrives in the S_DONE cycle -> two frame_valid pulses, both frames correct, no frame_err.
- Expiry race: RS_DONE asserted exactly at counter=TIMEOUT_CYCLES-1 -> byte accepted, no frame_err.
- Reset mid-frame: RST pulse after 0x05,0x50 -> all outputs 0, busy=0; a following full frame 0x06,0x60,0x12,0x34 is decoded correctly.
- RX_CHECKSUM_EN: 0x01,0x10,0xAB,0xCD,0x89 -> frame_valid. Same frame with checksum 0x88 -> frame_err only, outputs unchanged.

Source files
------------

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler
//   Assembles UART receive bytes into frames of
//   {command, ADDR_BYTES address bytes, DATA_BYTES data bytes}.
//   A complete frame is presented on cmd_rx/addr_rx/data_rx with a one-cycle
//   frame_valid strobe. A partial frame that stalls for TIMEOUT_CYCLES is
//   discarded with a one-cycle frame_err strobe.
//   Optional feature macro: RX_CHECKSUM_EN adds a trailing 8-bit additive
//   checksum byte; a mismatching frame is discarded with frame_err.
//
// Ports
//   CLK_50MHZ   in   system clock
//   RST         in   synchronous reset, active-high
//   RS_DATAOUT  in   [7:0] received byte, qualified by RS_DONE
//   RS_DONE     in   one-cycle byte-available pulse
//   frame_valid out  one-cycle pulse, new frame on the outputs
//   cmd_rx      out  [7:0] command byte of last good frame
//   addr_rx     out  [8*ADDR_BYTES-1:0] address, first byte = MSB
//   data_rx     out  [8*DATA_BYTES-1:0] data, first byte = MSB
//   frame_err   out  one-cycle pulse, partial/bad frame discarded
//   busy        out  high while a frame is partially received
module rx_frame_assembler #(
  parameter int unsigned ADDR_BYTES     = 1,
  parameter int unsigned DATA_BYTES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                    CLK_50MHZ,
  input  logic                    RST,
  input  logic [7:0]              RS_DATAOUT,
  input  logic                    RS_DONE,
  output logic                    frame_valid,
  output logic [7:0]              cmd_rx,
  output logic [8*ADDR_BYTES-1:0] addr_rx,
  output logic [8*DATA_BYTES-1:0] data_rx,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned BW   = $clog2(MAXB) + 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BYTES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
`ifdef RX_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [7:0]              r_cmd_sh,  w_cmd_sh_nxt;
  logic [8*ADDR_BYTES-1:0] r_addr_sh, w_addr_sh_nxt;
  logic [8*DATA_BYTES-1:0] r_data_sh, w_data_sh_nxt;
  logic [BW-1:0]           r_byte_cnt, w_byte_cnt_nxt;
  logic [TW-1:0]           r_to_cnt,  w_to_cnt_nxt;
  logic                    r_frame_valid, w_frame_valid_nxt;
  logic                    r_frame_err,   w_frame_err_nxt;
  logic [7:0]              r_cmd_rx,  w_cmd_rx_nxt;
  logic [8*ADDR_BYTES-1:0] r_addr_rx, w_addr_rx_nxt;
  logic [8*DATA_BYTES-1:0] r_data_rx, w_data_rx_nxt;
`ifdef RX_CHECKSUM_EN
  logic [7:0]              r_csum, w_csum_nxt;
`endif

  logic                    w_busy;
  logic                    w_timeout;
  logic [8*ADDR_BYTES-1:0] w_addr_ins;
  logic [8*DATA_BYTES-1:0] w_data_ins;

  // Shift-left-by-a-byte insertion; written without slicing so that a
  // single-byte field (width 8) needs no special case.
  assign w_addr_ins = (r_addr_sh << 8) | (8*ADDR_BYTES)'(RS_DATAOUT);
  assign w_data_ins = (r_data_sh << 8) | (8*DATA_BYTES)'(RS_DATAOUT);

`ifdef RX_CHECKSUM_EN
  assign w_busy = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CHK);
`else
  assign w_busy = (r_state == S_ADDR) || (r_state == S_DATA);
`endif

  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_timeout = w_busy && !RS_DONE && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_sh_nxt      = r_cmd_sh;
    w_addr_sh_nxt     = r_addr_sh;
    w_data_sh_nxt     = r_data_sh;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_frame_valid_nxt = 1'b0;
    w_frame_err_nxt   = 1'b0;
    w_cmd_rx_nxt      = r_cmd_rx;
    w_addr_rx_nxt     = r_addr_rx;
    w_data_rx_nxt     = r_data_rx;
`ifdef RX_CHECKSUM_EN
    w_csum_nxt        = r_csum;
`endif

    if (RS_DONE || !w_busy) begin
      w_to_cnt_nxt = '0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end

    if (w_timeout) begin
      w_frame_err_nxt = 1'b1;
      w_cmd_sh_nxt    = '0;
      w_addr_sh_nxt   = '0;
      w_data_sh_nxt   = '0;
      w_byte_cnt_nxt  = '0;
      w_to_cnt_nxt    = '0;
      w_state_nxt     = S_CMD;
`ifdef RX_CHECKSUM_EN
      w_csum_nxt      = '0;
`endif
    end else begin
      case (r_state)
        // S_DONE accepts a byte as the next command, so back-to-back frames
        // lose nothing.
        S_CMD, S_DONE: begin
          w_state_nxt = S_CMD;
          if (RS_DONE) begin
            w_cmd_sh_nxt   = RS_DATAOUT;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = S_ADDR;
`ifdef RX_CHECKSUM_EN
            w_csum_nxt     = RS_DATAOUT;
`endif
          end
        end
        S_ADDR: begin
          if (RS_DONE) begin
            w_addr_sh_nxt = w_addr_ins;
`ifdef RX_CHECKSUM_EN
            w_csum_nxt    = r_csum + RS_DATAOUT;
`endif
            if (r_byte_cnt == ADDR_LAST) begin
              w_byte_cnt_nxt = '0;
              w_state_nxt    = S_DATA;
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (RS_DONE) begin
            w_data_sh_nxt = w_data_ins;
`ifdef RX_CHECKSUM_EN
            w_csum_nxt    = r_csum + RS_DATAOUT;
`endif
            if (r_byte_cnt == DATA_LAST) begin
              w_byte_cnt_nxt = '0;
`ifdef RX_CHECKSUM_EN
              w_state_nxt    = S_CHK;
`else
              // Outputs are loaded on the edge into S_DONE so they are
              // already valid in the frame_valid cycle.
              w_state_nxt       = S_DONE;
              w_frame_valid_nxt = 1'b1;
              w_cmd_rx_nxt      = r_cmd_sh;
              w_addr_rx_nxt     = r_addr_sh;
              w_data_rx_nxt     = w_data_ins;
`endif
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            end
          end
        end
`ifdef RX_CHECKSUM_EN
        S_CHK: begin
          if (RS_DONE) begin
            if (RS_DATAOUT == r_csum) begin
              w_state_nxt       = S_DONE;
              w_frame_valid_nxt = 1'b1;
              w_cmd_rx_nxt      = r_cmd_sh;
              w_addr_rx_nxt     = r_addr_sh;
              w_data_rx_nxt     = r_data_sh;
            end else begin
              w_state_nxt     = S_CMD;
              w_frame_err_nxt = 1'b1;
            end
          end
        end
`endif
        default: begin
          w_state_nxt    = S_CMD;
          w_byte_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_state       <= S_CMD;
      r_cmd_sh      <= '0;
      r_addr_sh     <= '0;
      r_data_sh     <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_cmd_rx      <= '0;
      r_addr_rx     <= '0;
      r_data_rx     <= '0;
`ifdef RX_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_sh      <= w_cmd_sh_nxt;
      r_addr_sh     <= w_addr_sh_nxt;
      r_data_sh     <= w_data_sh_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_frame_err   <= w_frame_err_nxt;
      r_cmd_rx      <= w_cmd_rx_nxt;
      r_addr_rx     <= w_addr_rx_nxt;
      r_data_rx     <= w_data_rx_nxt;
`ifdef RX_CHECKSUM_EN
      r_csum        <= w_csum_nxt;
`endif
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign cmd_rx      = r_cmd_rx;
  assign addr_rx     = r_addr_rx;
  assign data_rx     = r_data_rx;
  assign busy        = w_busy;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb_rx_frame_assembler
//   Directed and randomized byte streams against a queue-based frame model.
//   Honours RX_CHECKSUM_EN when defined for the build.
module tb_rx_frame_assembler;

  localparam int unsigned AB = 1;
  localparam int unsigned DB = 2;
  localparam int unsigned TC = 100;
`ifdef RX_CHECKSUM_EN
  localparam int LEN = 1 + AB + DB + 1;
`else
  localparam int LEN = 1 + AB + DB;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rs_done = 1'b0;
  logic [7:0]        rs_data = '0;
  logic              frame_valid;
  logic [7:0]        cmd_rx;
  logic [8*AB-1:0]   addr_rx;
  logic [8*DB-1:0]   data_rx;
  logic              frame_err;
  logic              busy;

  rx_frame_assembler #(
    .ADDR_BYTES    (AB),
    .DATA_BYTES    (DB),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst),
    .RS_DATAOUT (rs_data),
    .RS_DONE    (rs_done),
    .frame_valid(frame_valid),
    .cmd_rx     (cmd_rx),
    .addr_rx    (addr_rx),
    .data_rx    (data_rx),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the open frame, time of the last accepted byte.
  logic [7:0]  m_q[$];
  int          m_last = 0;
  int          cyc = 0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [63:0] m_cmd = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_data = '0;
  int          err_seen = 0;
  int          vld_seen = 0;

  task automatic model_update(input logic r, input logic d, input logic [7:0] b);
    logic [63:0] a;
    logic [63:0] dd;
    logic [7:0]  s;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_q.delete();
      m_cmd  = '0;
      m_addr = '0;
      m_data = '0;
    end else if (m_q.size() != 0 && !d && (cyc - m_last >= int'(TC))) begin
      m_err = 1'b1;
      m_q.delete();
    end else if (d) begin
      m_q.push_back(b);
      m_last = cyc;
      if (m_q.size() == LEN) begin
        a = '0; dd = '0; s = '0;
        for (int i = 1; i <= int'(AB); i++) a = (a << 8) | 64'(m_q[i]);
        for (int i = 1 + int'(AB); i <= int'(AB + DB); i++) dd = (dd << 8) | 64'(m_q[i]);
        for (int i = 0; i <= int'(AB + DB); i++) s = s + m_q[i];
`ifdef RX_CHECKSUM_EN
        if (s != m_q[LEN-1]) begin
          m_err = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_cmd = 64'(m_q[0]); m_addr = a; m_data = dd;
        end
`else
        m_valid = 1'b1;
        m_cmd = 64'(m_q[0]); m_addr = a; m_data = dd;
`endif
        m_q.delete();
      end
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [7:0] b);
    rst = r; rs_done = d; rs_data = b;
    @(posedge clk);
    #1;
    model_update(r, d, b);
    check("frame_valid", 64'(frame_valid), 64'(m_valid));
    check("frame_err",   64'(frame_err),   64'(m_err));
    check("busy",        64'(busy),        64'(m_q.size() != 0));
    check("cmd_rx",      64'(cmd_rx),      m_cmd);
    check("addr_rx",     64'(addr_rx),     m_addr);
    check("data_rx",     64'(data_rx),     m_data);
    if (frame_err) err_seen++;
    if (frame_valid) vld_seen++;
    cyc++;
    rst = 1'b0; rs_done = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bl[$], input int gap);
    foreach (bl[i]) begin
      repeat (gap) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, bl[i]);
    end
  endtask

  task automatic with_csum(inout logic [7:0] bl[$]);
`ifdef RX_CHECKSUM_EN
    logic [7:0] s;
    s = '0;
    foreach (bl[i]) s = s + bl[i];
    bl.push_back(s);
`endif
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] s;
    int         n;
    int         g;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Frame timing with 20-cycle gaps
    fr = '{8'h01, 8'h10, 8'hAB, 8'hCD};
    with_csum(fr);
    vld_seen = 0;
    send_list(fr, 20);
    check("t1_valid_now", 64'(frame_valid), 64'd1);
    check("t1_cmd",  64'(cmd_rx),  64'h01);
    check("t1_addr", 64'(addr_rx), 64'h10);
    check("t1_data", 64'(data_rx), 64'hABCD);
    step(1'b0, 1'b0, 8'h00);
    check("t1_valid_once", 64'(vld_seen), 64'd1);

    // Timeout on a stalled partial frame
    err_seen = 0;
    fr = '{8'h02, 8'h20};
    send_list(fr, 3);
    repeat (TC + 20) step(1'b0, 1'b0, 8'h00);
    check("t2_err_once", 64'(err_seen), 64'd1);
    check("t2_data_kept", 64'(data_rx), 64'hABCD);
    fr = '{8'h03, 8'h30, 8'h11, 8'h22};
    with_csum(fr);
    send_list(fr, 2);
    check("t2_cmd",  64'(cmd_rx),  64'h03);
    check("t2_addr", 64'(addr_rx), 64'h30);
    check("t2_data", 64'(data_rx), 64'h1122);

    // Back-to-back frames, second command lands in the done cycle
    err_seen = 0; vld_seen = 0;
    fr = '{8'hA1, 8'h1A, 8'h55, 8'h66};
    with_csum(fr);
    send_list(fr, 0);
    fr = '{8'hB2, 8'h2B, 8'h77, 8'h88};
    with_csum(fr);
    send_list(fr, 0);
    check("t3_data2", 64'(data_rx), 64'h7788);
    step(1'b0, 1'b0, 8'h00);
    check("t3_two_valid", 64'(vld_seen), 64'd2);
    check("t3_no_err", 64'(err_seen), 64'd0);

    // Expiry race: every byte arrives exactly in the expiry cycle
    err_seen = 0;
    fr = '{8'h07, 8'h70, 8'h9A, 8'hBC};
    with_csum(fr);
    send_list(fr, TC - 1);
    check("t4_no_err", 64'(err_seen), 64'd0);
    check("t4_data", 64'(data_rx), 64'h9ABC);

    // Reset mid-frame
    err_seen = 0;
    fr = '{8'h05, 8'h50};
    send_list(fr, 1);
    step(1'b1, 1'b0, 8'h00);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_cmd0", 64'(cmd_rx), 64'd0);
    fr = '{8'h06, 8'h60, 8'h12, 8'h34};
    with_csum(fr);
    send_list(fr, 1);
    check("t5_data", 64'(data_rx), 64'h1234);
    check("t5_no_err", 64'(err_seen), 64'd0);

`ifdef RX_CHECKSUM_EN
    // Bad checksum: error only, outputs held
    err_seen = 0; vld_seen = 0;
    fr = '{8'h01, 8'h10, 8'hAB, 8'hCD, 8'h88};
    send_list(fr, 2);
    check("t6_err_now", 64'(frame_err), 64'd1);
    check("t6_data_kept", 64'(data_rx), 64'h1234);
    check("t6_no_valid", 64'(vld_seen), 64'd0);
`endif

    // Randomized frames, gaps near the timeout, truncations, resets
    for (int f = 0; f < 80; f++) begin
      fr.delete();
      n = LEN;
      if ($urandom_range(0, 7) == 0) n = $urandom_range(1, LEN - 1);
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
`ifdef RX_CHECKSUM_EN
      if (n == LEN && $urandom_range(0, 3) != 0) begin
        s = '0;
        for (int i = 0; i < LEN - 1; i++) s = s + fr[i];
        fr[LEN-1] = s;
      end
`endif
      foreach (fr[i]) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: g = $urandom_range(0, 3);
          6, 7:             g = int'(TC) - 2 + int'($urandom_range(0, 3));
          default:          g = 0;
        endcase
        repeat (g) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, fr[i]);
      end
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 8'h00);
    end
    repeat (TC + 5) step(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
